// File: rtl/x25519_pkg.sv
// Shared types and constants for the X25519 multiplier arbitration slice.
package x25519_pkg;

  // Operand/result width of the X25519 field multiplier.
  localparam int X25519_WIDTH = 264;

  // Arbiter states. FAULT is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/x25519_rr_pick.sv
// Combinational circular priority picker: finds the first set request bit
// at or after ptr_i (wrapping around) and returns it one-hot plus its index.
module x25519_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] pos;

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/x25519_mult_arbiter.sv
// Round-robin arbiter sharing one X25519 multiplier among NUM_REQ requesters.
// Exactly one operation is in flight at a time; the result goes back to the
// requester that issued it.
// Optional watchdog: define X25519_MULT_ARB_TIMEOUT_EN to add a BUSY-cycle
// counter that answers with rsp_err and latches a sticky fault when the
// multiplier never responds.
module x25519_mult_arbiter
  import x25519_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = X25519_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     rsp_err,
  output logic                     fault,
  output logic                     mult_en,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_out_valid,
  input  logic [WIDTH-1:0]         mult_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("x25519_mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             mult_en_q, mult_en_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

`ifdef X25519_MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             fault_q, fault_d;
`endif

  logic [WIDTH-1:0]   op_a [NUM_REQ];
  logic [WIDTH-1:0]   op_b [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*WIDTH +: WIDTH];
    assign op_b[g] = req_b[g*WIDTH +: WIDTH];
  end

  x25519_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Next-state logic: grant in IDLE, wait for the result (or timeout) in BUSY.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    rsp_out_d   = rsp_out_q;
    mult_en_d   = 1'b0;
    req_ack_d   = '0;
    rsp_valid_d = '0;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
    fault_d     = fault_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d   = pick_idx;
          mult_a_d  = op_a[pick_idx];
          mult_b_d  = op_b[pick_idx];
          mult_en_d = 1'b1;
          req_ack_d = pick_grant;
          state_d   = BUSY;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      BUSY: begin
        if (mult_out_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_out_d            = mult_out;
          rr_ptr_d             = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          state_d              = IDLE;
        end
`ifdef X25519_MULT_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_out_d            = '0;
          rsp_err_d            = 1'b1;
          fault_d              = 1'b1;
          state_d              = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

`ifdef X25519_MULT_ARB_TIMEOUT_EN
      FAULT: begin
        state_d = FAULT;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      rsp_out_q   <= '0;
      mult_en_q   <= 1'b0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      rsp_out_q   <= rsp_out_d;
      mult_en_q   <= mult_en_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign mult_en   = mult_en_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;

`ifdef X25519_MULT_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
  assign fault   = fault_q;
`else
  assign rsp_err = 1'b0;
  assign fault   = 1'b0;
`endif

endmodule
